// File: rtl/execute_muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : execute_muldiv_ctrl_pkg
//  Brief    : Shared execute-stage types: muldiv opcodes, sequencer states,
//             iteration count and the execute context record.
//  Revision : 1.0 - initial release
// ============================================================================
package execute_muldiv_ctrl_pkg;

   // One iteration per data bit.
   localparam int MULDIV_ITERS = 32;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } muldiv_op_t;

   typedef enum logic [1:0] {
      MD_S_IDLE = 2'd0,
      MD_S_RUN  = 2'd1,
      MD_S_FIX  = 2'd2
   } md_state_t;

   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_DIV = 1'b1
   } muldiv_mode_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        in_delay_slot;
      logic [4:0]  exc_code;
   } execute_context_t;

   // Two's-complement magnitude; 0x8000_0000 maps to 2^31 as an unsigned value.
   function automatic logic [31:0] md_abs32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/execute_muldiv_ctrl_iter.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_iter
//  Brief    : 64-bit work register with one shift-add (multiply) or one
//             restoring-subtract (divide) step per enabled cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter
   import execute_muldiv_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,       // start a new operation
   input  logic         step_i,       // advance one iteration
   input  muldiv_mode_t mode_i,
   input  logic [31:0]  work_lo_i,    // multiplier or dividend magnitude
   input  logic [31:0]  opnd_i,       // multiplicand or divisor magnitude
   output logic [63:0]  product_o,
   output logic [31:0]  quotient_o,
   output logic [31:0]  remainder_o
);

   logic [63:0] work_q, work_d;
   logic [31:0] opnd_q;

   // Multiply: add the multiplicand into the upper half when the LSB is set,
   // then shift the whole register right, keeping the carry.
   logic [32:0] w_madd;
   logic [63:0] w_mul_next;
   assign w_madd     = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
   assign w_mul_next = {w_madd, work_q[31:1]};

   // Divide: shift left one bit, try a 33-bit subtract of the divisor from the
   // partial remainder, keep it when non-negative and shift in the quotient bit.
   logic [32:0] w_part;
   logic [31:0] w_diff;
   logic        w_ge;
   logic [63:0] w_div_next;
   assign w_part     = work_q[63:31];
   assign w_ge       = (w_part >= {1'b0, opnd_q});
   assign w_diff     = w_part[31:0] - opnd_q;
   assign w_div_next = {(w_ge ? w_diff : w_part[31:0]), work_q[30:0], w_ge};

   // Next value of the work register.
   always_comb begin
      work_d = work_q;
      if (load_i) begin
         work_d = {32'd0, work_lo_i};
      end else if (step_i) begin
         work_d = (mode_i == MODE_DIV) ? w_div_next : w_mul_next;
      end
   end

   // Work and operand registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         work_q <= 64'd0;
         opnd_q <= 32'd0;
      end else begin
         work_q <= work_d;
         if (load_i) begin
            opnd_q <= opnd_i;
         end
      end
   end

   assign product_o   = work_q;
   assign quotient_o  = work_q[31:0];
   assign remainder_o = work_q[63:32];

endmodule
`default_nettype wire

// File: rtl/execute_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : execute_muldiv_ctrl
//  Brief    : Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; handles
//             MTHI/MTLO, sign fix-up, divide-by-zero results and flush.
//  Revision : 1.0 - initial release
// ============================================================================
module execute_muldiv_ctrl
   import execute_muldiv_ctrl_pkg::*;
#(
   parameter int ITERS = MULDIV_ITERS
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  muldiv_op_t  req_op,
   input  logic [31:0] vs,
   input  logic [31:0] vt,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CW = $clog2(ITERS);
   localparam logic [CW-1:0] C_LAST = CW'(ITERS - 1);

   md_state_t   state_q;
   logic [CW-1:0] count_q;
   muldiv_op_t  op_q;
   logic        neg_res_q;   // quotient/product sign differs from magnitude
   logic        neg_rem_q;   // remainder follows a negative dividend
   logic        dz_q;        // divisor was zero
   logic [31:0] vs_q;        // original dividend, returned as HI on divide-by-zero
   logic [31:0] hi_q, lo_q;

   // Request decode.
   logic        w_accept, w_signed, w_arith, w_div_req;
   logic [31:0] w_vs_mag, w_vt_mag;
   assign w_accept  = req_valid && (state_q == MD_S_IDLE) && !flush;
   assign w_signed  = (req_op == MD_MULT) || (req_op == MD_DIV);
   assign w_div_req = (req_op == MD_DIV)  || (req_op == MD_DIVU);
   assign w_arith   = w_div_req || (req_op == MD_MULT) || (req_op == MD_MULTU);
   assign w_vs_mag  = md_abs32(vs, w_signed);
   assign w_vt_mag  = md_abs32(vt, w_signed);

   // Shared datapath.
   logic         w_op_div;
   logic [63:0]  w_product;
   logic [31:0]  w_quot, w_rem;
   assign w_op_div = (op_q == MD_DIV) || (op_q == MD_DIVU);

   muldiv_iter u_iter (
      .clk         (clk),
      .reset       (reset),
      .load_i      (w_accept && w_arith),
      .step_i      (state_q == MD_S_RUN),
      .mode_i      (w_op_div ? MODE_DIV : MODE_MUL),
      .work_lo_i   (w_div_req ? w_vs_mag : w_vt_mag),
      .opnd_i      (w_div_req ? w_vt_mag : w_vs_mag),
      .product_o   (w_product),
      .quotient_o  (w_quot),
      .remainder_o (w_rem)
   );

   // Sign-corrected result committed at the end of the FIX cycle.
   logic [31:0] res_hi_d, res_lo_d;
   logic [63:0] w_prod_s;
   always_comb begin
      w_prod_s = neg_res_q ? (~w_product + 64'd1) : w_product;
      res_hi_d = w_prod_s[63:32];
      res_lo_d = w_prod_s[31:0];
      if (w_op_div) begin
         if (dz_q) begin
            res_hi_d = vs_q;
            res_lo_d = ((op_q == MD_DIV) && vs_q[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
         end else begin
            res_lo_d = neg_res_q ? (~w_quot + 32'd1) : w_quot;
            res_hi_d = neg_rem_q ? (~w_rem + 32'd1) : w_rem;
         end
      end
   end

   // Sequencer FSM with HI/LO ownership; flush aborts without touching HI/LO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= MD_S_IDLE;
         count_q   <= '0;
         op_q      <= MD_MULT;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         vs_q      <= 32'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else if (flush) begin
         state_q <= MD_S_IDLE;
         count_q <= '0;
      end else begin
         case (state_q)
            MD_S_IDLE: begin
               if (req_valid) begin
                  if (req_op == MD_MTHI) begin
                     hi_q <= vs;
                  end else if (req_op == MD_MTLO) begin
                     lo_q <= vs;
                  end else if (w_arith) begin
                     op_q      <= req_op;
                     neg_res_q <= w_signed && (vs[31] ^ vt[31]);
                     neg_rem_q <= w_signed && vs[31];
                     dz_q      <= (vt == 32'd0);
                     vs_q      <= vs;
                     count_q   <= '0;
                     state_q   <= MD_S_RUN;
                  end
               end
            end
            MD_S_RUN: begin
               count_q <= count_q + CW'(1);
               if (count_q == C_LAST) begin
                  state_q <= MD_S_FIX;
               end
            end
            MD_S_FIX: begin
               hi_q    <= res_hi_d;
               lo_q    <= res_lo_d;
               state_q <= MD_S_IDLE;
            end
            default: begin
               state_q <= MD_S_IDLE;
            end
         endcase
      end
   end

   assign busy = (state_q != MD_S_IDLE);
   assign done = (state_q == MD_S_FIX);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_execute_muldiv_ctrl
//  Brief    : Directed vector table plus hand-written flush/reset/stall
//             sequences for execute_muldiv_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_execute_muldiv_ctrl;
   import execute_muldiv_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   muldiv_op_t  req_op;
   logic [31:0] vs, vt;
   logic        flush;
   logic        busy, done;
   logic [31:0] hi, lo;

   execute_muldiv_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_op    (req_op),
      .vs        (vs),
      .vt        (vt),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int busy_cnt, done_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present a request at a negedge; it is taken at the following posedge.
   task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
      req_valid = 1'b1;
      req_op    = op;
      vs        = a;
      vt        = b;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Count busy and done cycles until the unit returns to idle.
   task automatic wait_idle();
      busy_cnt = 0;
      done_cnt = 0;
      while (busy === 1'b1 && busy_cnt < 100) begin
         busy_cnt++;
         if (done === 1'b1) done_cnt++;
         @(negedge clk);
      end
   endtask

   typedef struct {
      muldiv_op_t  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ehi;
      logic [31:0] elo;
      int          ebusy;
   } vec_t;

   vec_t vecs[16];

   initial begin
      int guard;
      int lo5_seen;

      vecs[0]  = '{MD_MTLO,  32'h0000_0005, 32'h0,          32'h0000_0000, 32'h0000_0005, 0};
      vecs[1]  = '{MD_MTHI,  32'hAAAA_AAAA, 32'h0,          32'hAAAA_AAAA, 32'h0000_0005, 0};
      vecs[2]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 33};
      vecs[3]  = '{MD_MULT,  32'hFFFF_FFFD, 32'h0000_0005,  32'hFFFF_FFFF, 32'hFFFF_FFF1, 33};
      vecs[4]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002,  32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
      vecs[5]  = '{MD_DIVU,  32'h0000_1234, 32'h0000_0000,  32'h0000_1234, 32'hFFFF_FFFF, 33};
      vecs[6]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 33};
      vecs[7]  = '{MD_DIV,   32'hFFFF_FFF8, 32'h0000_0000,  32'hFFFF_FFF8, 32'h0000_0001, 33};
      vecs[8]  = '{MD_DIV,   32'h0000_0005, 32'h0000_0000,  32'h0000_0005, 32'hFFFF_FFFF, 33};
      vecs[9]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 33};
      vecs[10] = '{MD_MULTU, 32'h1234_5678, 32'h0000_0010,  32'h0000_0001, 32'h2345_6780, 33};
      vecs[11] = '{MD_DIVU,  32'h0000_0064, 32'h0000_0007,  32'h0000_0002, 32'h0000_000E, 33};
      vecs[12] = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, 33};
      vecs[13] = '{MD_MULT,  32'h0000_0007, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFF9, 33};
      vecs[14] = '{MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0001,  32'h0000_0000, 32'hFFFF_FFFF, 33};
      vecs[15] = '{MD_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE,  32'hFFFF_FFFF, 32'h0000_0003, 33};

      reset = 1'b1; req_valid = 1'b0; req_op = MD_MULT; vs = '0; vt = '0; flush = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Vector table; each op is issued in the first idle cycle after the last.
      for (int i = 0; i < 16; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_idle();
         chk($sformatf("vec%0d_hi", i), hi, vecs[i].ehi);
         chk($sformatf("vec%0d_lo", i), lo, vecs[i].elo);
         chk($sformatf("vec%0d_busy_cycles", i), 32'(busy_cnt), 32'(vecs[i].ebusy));
         chk($sformatf("vec%0d_done_pulses", i), 32'(done_cnt), (vecs[i].ebusy != 0) ? 32'd1 : 32'd0);
      end

      // Flush at RUN cycle 10: abort, no done, HI/LO untouched.
      issue(MD_MTHI, 32'hAAAA_AAAA, 32'h0);
      issue(MD_MTLO, 32'h5555_5555, 32'h0);
      issue(MD_DIV, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      chk("flush_busy_before", 32'(busy), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy_after", 32'(busy), 32'd0);
      done_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         if (done === 1'b1 || busy === 1'b1) done_cnt++;
         @(negedge clk);
      end
      chk("flush_no_done", 32'(done_cnt), 32'd0);
      chk("flush_hi", hi, 32'hAAAA_AAAA);
      chk("flush_lo", lo, 32'h5555_5555);

      // Asynchronous reset mid-run clears everything at once.
      issue(MD_DIV, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("areset_busy", 32'(busy), 32'd0);
      chk("areset_done", 32'(done), 32'd0);
      chk("areset_hi", hi, 32'd0);
      chk("areset_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // MTLO held under stall is taken only once the unit is idle.
      req_valid = 1'b1; req_op = MD_MULT; vs = 32'd3; vt = 32'd5;
      @(negedge clk);
      req_op = MD_MTLO; vs = 32'h0000_0005; vt = 32'h0;
      busy_cnt = 0;
      lo5_seen = 0;
      while (busy === 1'b1 && busy_cnt < 100) begin
         busy_cnt++;
         if (lo === 32'h0000_0005) lo5_seen++;
         @(negedge clk);
      end
      chk("stall_busy_cycles", 32'(busy_cnt), 32'd33);
      chk("stall_mtlo_early", 32'(lo5_seen), 32'd0);
      chk("stall_mult_lo", lo, 32'h0000_000F);
      @(negedge clk);
      req_valid = 1'b0;
      chk("stall_mtlo_lo", lo, 32'h0000_0005);
      chk("stall_mtlo_busy", 32'(busy), 32'd0);
      chk("stall_hi", hi, 32'h0000_0000);

      // Flush during FIX: no commit, back to idle.
      issue(MD_MULTU, 32'd2, 32'd3);
      guard = 0;
      while (done !== 1'b1 && guard < 100) begin
         guard++;
         @(negedge clk);
      end
      chk("fixflush_reached_fix", 32'(done), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("fixflush_busy", 32'(busy), 32'd0);
      chk("fixflush_hi", hi, 32'h0000_0000);
      chk("fixflush_lo", lo, 32'h0000_0005);
      @(negedge clk);
      chk("fixflush_done_after", 32'(done), 32'd0);
      chk("fixflush_lo_later", lo, 32'h0000_0005);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/execute_muldiv_ctrl.md
# execute_muldiv_ctrl

Iterative multiply/divide sequencer for the execute stage. Owns the architectural HI/LO registers. Runs MULT/MULTU/DIV/DIVU over 32 iteration cycles on a shared shift-add/restoring datapath, and applies MTHI/MTLO writes. It stalls the pipeline through `busy` and aborts cleanly on an exception flush, while the single-cycle ALU handles every other opcode.

## Interface
Parameters:
- `ITERS`, default 32: iteration count; fixed to the data width, not meant to be overridden.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  execute stage presents a muldiv op this cycle.
- `req_op`  in  `muldiv_op_t`  one of MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
- `vs`  in  32  rs operand; the dividend, the multiplicand, or the MTHI/MTLO source.
- `vt`  in  32  rt operand; the divisor or the multiplier.
- `flush`  in  1  exception/ERET flush; kills any in-flight op.
- `busy`  out  1  unit occupied; execute stage stalls on any muldiv/MFHI/MFLO while high.
- `done`  out  1  one-cycle pulse in the cycle before HI/LO take the new result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States:
  - IDLE: accepting requests.
  - RUN: iterating; holds a 5-bit count and a 64-bit work register.
  - FIX: sign correction and commit.
- A request is accepted when `req_valid && state==IDLE && !flush`.
- MTHI/MTLO: `hi` or `lo` takes `vs` at the accept edge; the state stays IDLE and `busy` stays low.
- MULT/DIV accept edge:
  - Latch operand magnitudes. Signed ops take the 2's-complement absolute value, so 0x8000_0000 becomes magnitude 2^31.
  - Latch the sign flags and the op.
  - Set count=0 and go to RUN.
- RUN, multiply: one shift-add step per cycle on the 64-bit product.
- RUN, divide: one restoring step per cycle, with a 33-bit partial-remainder subtract.
- RUN exit: after count reaches 31 (32 RUN cycles), go to FIX.
- FIX, MULT: negate the 64-bit product if the signs differ.
- FIX, DIV:
  - Negate the quotient if the signs differ.
  - The remainder takes the sign of the dividend.
- FIX commit: at the FIX exit edge `{hi,lo}` take the result and the state returns to IDLE.
- Divide by zero, all three cases below, with no exception raised:
  - DIVU: LO=0xFFFF_FFFF, HI=vs.
  - DIV with vs>=0: LO=0xFFFF_FFFF, HI=vs.
  - DIV with vs<0: LO=0x0000_0001, HI=vs.
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0. This falls out of the magnitude arithmetic.
- `busy` = (state != IDLE), combinational from state.
- `done` = (state == FIX).
- `req_valid` while busy is ignored; the requester holds its request under stall.
- `flush`:
  - Synchronous; on the edge, the state goes to IDLE.
  - HI/LO stay unchanged, including when flush arrives during FIX.
  - A same-cycle request is dropped.
- `reset` (async, any state): state=IDLE, count=0, hi=0, lo=0, busy=0, done=0.

## Timing
- Accept edge E0. RUN occupies cycles E0+1..E0+32. FIX is cycle E0+33. HI/LO are visible from E0+34.
- `busy` is high for exactly 33 cycles per MULT/DIV.
- Back-to-back: a new request can be accepted in the first IDLE cycle, E0+34.
- MTHI/MTLO latency: 1 edge; the value is readable the next cycle.
- Output widths are 32 bits with no truncation ambiguity:
  - Product: HI = bits 63:32, LO = bits 31:0.
  - Division: LO = quotient, HI = remainder.

## Structure
- Shared package, alongside `execute_context_t`:
  - `muldiv_op_t` enum.
  - `MULDIV_ITERS`=32 constant.
- Sub-module `muldiv_iter`: the 64-bit work register and the one-step add/subtract. It has a `step` enable plus a `mode` (mul/div) and exposes its product, quotient and remainder.
- The FSM, sign handling, divide-by-zero override, flush, and HI/LO registers live in `execute_muldiv_ctrl`.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF:
  - `busy` is high for 33 cycles.
  - `done` pulses once.
  - Result: HI=0xFFFF_FFFE, LO=0x0000_0001.
- MULT −3 × 5, then DIV −7 / 2, issued back-to-back in the first IDLE cycle:
  - After the MULT: HI=0xFFFF_FFFF, LO=0xFFFF_FFF1.
  - After the DIV: LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
- Divide-by-zero and overflow cases:
  - DIVU 0x1234 / 0: LO=0xFFFF_FFFF, HI=0x1234.
  - DIV 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0.
- Flush and reset mid-operation:
  - Preload HI=0xAAAA_AAAA via MTHI. Start DIV and assert `flush` at RUN cycle 10. Expected: `busy` low the next cycle, no `done`, HI=0xAAAA_AAAA.
  - Repeat the run with async `reset` in place of flush. Expected: HI=LO=0 and `busy`=0 immediately.
- MTLO 0x5 while busy: held (ignored) until IDLE, then LO=0x5 one cycle after acceptance with `busy` never asserted by it.
- Flush during the FIX cycle: HI/LO keep their prior values and the state returns to IDLE.
